// File: rtl/gonso_wb_master.sv
// Wishbone classic single-transfer master.
// Takes one command at a time on a valid/ready port, runs a single
// Wishbone cycle with an optional ack/err timeout, and returns the
// result on a valid/ready response port. All outputs are registered.
module gonso_wb_master #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i
);

  // Counter is wide enough to hold TIMEOUT itself, where it saturates.
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_RESP
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              cmd_ready_n;
  logic              cyc_n, we_n;
  logic [31:0]       adr_n, dat_n;
  logic [3:0]        sel_n;
  logic              rsp_valid_n, rsp_err_n, rsp_timeout_n;
  logic [31:0]       rsp_rdata_n;

  // Next-state and next-output logic; every register holds by default.
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    cyc_n         = wbm_cyc_o;
    we_n          = wbm_we_o;
    adr_n         = wbm_adr_o;
    dat_n         = wbm_dat_o;
    sel_n         = wbm_sel_o;
    rsp_valid_n   = rsp_valid;
    rsp_rdata_n   = rsp_rdata;
    rsp_err_n     = rsp_err;
    rsp_timeout_n = rsp_timeout;

    case (state)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_n = S_BUS;
          cyc_n   = 1'b1;
          we_n    = cmd_we;
          adr_n   = cmd_addr;
          dat_n   = cmd_wdata;
          sel_n   = cmd_sel;
          cnt_n   = '0;
        end
      end
      S_BUS: begin
        // err beats ack, and either beats a timeout in the same cycle.
        if (wbm_err_i) begin
          state_n       = S_RESP;
          cyc_n         = 1'b0;
          rsp_valid_n   = 1'b1;
          rsp_rdata_n   = '0;
          rsp_err_n     = 1'b1;
          rsp_timeout_n = 1'b0;
        end else if (wbm_ack_i) begin
          state_n       = S_RESP;
          cyc_n         = 1'b0;
          rsp_valid_n   = 1'b1;
          rsp_rdata_n   = wbm_we_o ? 32'd0 : wbm_dat_i;
          rsp_err_n     = 1'b0;
          rsp_timeout_n = 1'b0;
        end else if ((TIMEOUT > 0) && (cnt == CNT_LAST)) begin
          state_n       = S_RESP;
          cyc_n         = 1'b0;
          rsp_valid_n   = 1'b1;
          rsp_rdata_n   = '0;
          rsp_err_n     = 1'b1;
          rsp_timeout_n = 1'b1;
        end else if (cnt != CNT_MAX) begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_n     = S_IDLE;
          rsp_valid_n = 1'b0;
        end
      end
      default: state_n = S_IDLE;
    endcase

    cmd_ready_n = (state_n == S_IDLE);
  end

  // State and registered outputs; reset clears everything and drops the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      cmd_ready   <= 1'b0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      wbm_sel_o   <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      cmd_ready   <= cmd_ready_n;
      wbm_cyc_o   <= cyc_n;
      wbm_stb_o   <= cyc_n;
      wbm_we_o    <= we_n;
      wbm_adr_o   <= adr_n;
      wbm_dat_o   <= dat_n;
      wbm_sel_o   <= sel_n;
      rsp_valid   <= rsp_valid_n;
      rsp_rdata   <= rsp_rdata_n;
      rsp_err     <= rsp_err_n;
      rsp_timeout <= rsp_timeout_n;
    end
  end

endmodule

// File: tb/tb_gonso_wb_master.sv
// Directed bench for gonso_wb_master with TIMEOUT=8.
module tb_gonso_wb_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic [3:0]  wbm_sel_o;
  logic        wbm_ack_i, wbm_err_i;

  int n_checks = 0;
  int n_errors = 0;

  gonso_wb_master #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command, wait (bounded) for acceptance; returns in first BUS cycle.
  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] sel);
    int waited;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_sel   = sel;
    waited = 0;
    while (!cmd_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!cmd_ready) check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
    check("stb_eq_cyc", {31'd0, wbm_stb_o}, {31'd0, wbm_cyc_o});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_sel = '0; rsp_ready = 1'b1; wbm_dat_i = '0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_cyc", {31'd0, wbm_cyc_o}, 32'd0);
    check("rst_stb", {31'd0, wbm_stb_o}, 32'd0);
    check("rst_we", {31'd0, wbm_we_o}, 32'd0);
    check("rst_adr", wbm_adr_o, 32'd0);
    check("rst_dat", wbm_dat_o, 32'd0);
    check("rst_sel", {28'd0, wbm_sel_o}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_rsp_to", {31'd0, rsp_timeout}, 32'd0);
    rst = 1'b0;
    tick(); tick();
    check("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

    // Write, ack two cycles after stb
    issue(1'b1, 32'h3003_0004, 32'h000A_BCDE, 4'hF);
    for (int i = 0; i < 3; i++) begin
      check("wr_cyc", {31'd0, wbm_cyc_o}, 32'd1);
      check("wr_we", {31'd0, wbm_we_o}, 32'd1);
      check("wr_adr", wbm_adr_o, 32'h3003_0004);
      check("wr_dat", wbm_dat_o, 32'h000A_BCDE);
      check("wr_sel", {28'd0, wbm_sel_o}, 32'hF);
      check("wr_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      if (i == 2) begin
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'hDEAD_BEEF;
      end
      tick();
    end
    wbm_ack_i = 1'b0;
    check("wr_cyc_drop", {31'd0, wbm_cyc_o}, 32'd0);
    check("wr_stb_drop", {31'd0, wbm_stb_o}, 32'd0);
    check("wr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("wr_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("wr_rsp_rdata", rsp_rdata, 32'd0);
    tick();
    check("wr_idle_valid", {31'd0, rsp_valid}, 32'd0);
    check("wr_idle_ready", {31'd0, cmd_ready}, 32'd1);

    // Read with zero-wait ack; also 3-cycle spacing
    issue(1'b0, 32'h3003_0008, 32'h0, 4'hF);
    check("rd_we", {31'd0, wbm_we_o}, 32'd0);
    check("rd_adr", wbm_adr_o, 32'h3003_0008);
    wbm_ack_i = 1'b1; wbm_dat_i = 32'h0001_2345;
    tick();
    wbm_ack_i = 1'b0;
    check("rd_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("rd_rsp_rdata", rsp_rdata, 32'h0001_2345);
    check("rd_rsp_err", {31'd0, rsp_err}, 32'd0);
    tick();
    check("rd_spacing_ready", {31'd0, cmd_ready}, 32'd1);

    // Timeout: no ack for a read
    issue(1'b0, 32'h3003_000C, 32'h0, 4'hF);
    cycles = 0;
    while (wbm_cyc_o && cycles < 20) begin
      cycles++;
      tick();
    end
    check("to_cyc_cycles", 32'(cycles), 32'd8);
    check("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("to_rsp_err", {31'd0, rsp_err}, 32'd1);
    check("to_rsp_timeout", {31'd0, rsp_timeout}, 32'd1);
    check("to_rsp_rdata", rsp_rdata, 32'd0);
    wbm_ack_i = 1'b1; wbm_dat_i = 32'h5555_5555;
    tick();
    check("late_ack_valid", {31'd0, rsp_valid}, 32'd0);
    tick();
    wbm_ack_i = 1'b0;
    check("late_ack_cyc", {31'd0, wbm_cyc_o}, 32'd0);
    check("late_ack_valid2", {31'd0, rsp_valid}, 32'd0);
    check("late_ack_ready", {31'd0, cmd_ready}, 32'd1);

    // Ack and err together: err wins
    issue(1'b0, 32'h3003_0010, 32'h0, 4'h3);
    wbm_ack_i = 1'b1; wbm_err_i = 1'b1; wbm_dat_i = 32'h1234_5678;
    tick();
    wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
    check("ae_rsp_err", {31'd0, rsp_err}, 32'd1);
    check("ae_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
    check("ae_rsp_rdata", rsp_rdata, 32'd0);
    tick();

    // Ack in the timeout cycle wins over the timeout
    issue(1'b0, 32'h3003_0014, 32'h0, 4'hF);
    for (int i = 0; i < 7; i++) tick();
    check("tc_cyc_still", {31'd0, wbm_cyc_o}, 32'd1);
    wbm_ack_i = 1'b1; wbm_dat_i = 32'hA5A5_A5A5;
    tick();
    wbm_ack_i = 1'b0;
    check("tc_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("tc_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
    check("tc_rsp_rdata", rsp_rdata, 32'hA5A5_A5A5);
    tick();

    // Back-pressure on the response
    rsp_ready = 1'b0;
    issue(1'b0, 32'h3003_0018, 32'h0, 4'hF);
    wbm_ack_i = 1'b1; wbm_dat_i = 32'h0BAD_F00D;
    tick();
    wbm_ack_i = 1'b0; wbm_dat_i = 32'h0;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_rdata", rsp_rdata, 32'h0BAD_F00D);
      check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
    check("bp_release_ready", {31'd0, cmd_ready}, 32'd1);

    // Reset pulse mid-BUS
    issue(1'b1, 32'h3003_001C, 32'h1111_2222, 4'hC);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_cyc", {31'd0, wbm_cyc_o}, 32'd0);
    check("mr_stb", {31'd0, wbm_stb_o}, 32'd0);
    check("mr_valid", {31'd0, rsp_valid}, 32'd0);
    tick();
    check("mr_valid2", {31'd0, rsp_valid}, 32'd0);
    check("mr_ready", {31'd0, cmd_ready}, 32'd1);
    issue(1'b0, 32'h3003_0020, 32'h0, 4'hF);
    check("mr_rd_adr", wbm_adr_o, 32'h3003_0020);
    wbm_ack_i = 1'b1; wbm_dat_i = 32'h0C0F_FEE0;
    tick();
    wbm_ack_i = 1'b0;
    check("mr_rd_valid", {31'd0, rsp_valid}, 32'd1);
    check("mr_rd_rdata", rsp_rdata, 32'h0C0F_FEE0);
    check("mr_rd_err", {31'd0, rsp_err}, 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
